// File: rtl/dmem_dump_ctrl.sv
// End-of-program monitor: counts cycles, detects the terminating NOP, then takes the DMEM
// port from the CPU after a flush window and streams every location out over valid/ready.
module dmem_dump_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 5,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned AW           = 9,
    parameter int unsigned DW           = 64
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [0:31]   instruction,
    input  logic          cpu_memEn,
    input  logic          cpu_memWrEn,
    input  logic [0:AW-1] cpu_memAddr,
    input  logic [0:DW-1] cpu_dataOut,
    output logic          dmem_memEn,
    output logic          dmem_memWrEn,
    output logic [0:AW-1] dmem_memAddr,
    output logic [0:DW-1] dmem_dataIn,
    input  logic [0:DW-1] dmem_dataOut,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [0:AW-1] dump_addr,
    output logic [0:DW-1] dump_data,
    output logic [0:31]   cycle_count,
    output logic [0:31]   final_cycles,
    output logic          done
);

    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [0:FW-1] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [0:AW-1] PTR_LAST   = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StRun,
        StFlush,
        StIssue,
        StCapture,
        StHold,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [0:AW-1] ptr_q, ptr_d;
    logic [0:FW-1] flush_cnt_q, flush_cnt_d;
    logic [0:31]   cycle_count_q, cycle_count_d;
    logic [0:31]   final_cycles_q, final_cycles_d;
    logic [0:AW-1] dump_addr_q, dump_addr_d;
    logic [0:DW-1] dump_data_q, dump_data_d;
    logic          dump_valid_q, dump_valid_d;

    // Reset is synchronous, so it is folded into the next-state logic.
    always_ff @(posedge CLK) begin
        state_q        <= state_d;
        ptr_q          <= ptr_d;
        flush_cnt_q    <= flush_cnt_d;
        cycle_count_q  <= cycle_count_d;
        final_cycles_q <= final_cycles_d;
        dump_addr_q    <= dump_addr_d;
        dump_data_q    <= dump_data_d;
        dump_valid_q   <= dump_valid_d;
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        flush_cnt_d    = flush_cnt_q;
        final_cycles_d = final_cycles_q;
        dump_addr_d    = dump_addr_q;
        dump_data_d    = dump_data_q;
        dump_valid_d   = dump_valid_q;
        cycle_count_d  = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q
                                                           : cycle_count_q + 32'd1;

        case (state_q)
            StRun: begin
                if (instruction == 32'h0000_0000) begin
                    final_cycles_d = cycle_count_q;
                    flush_cnt_d    = '0;
                    state_d        = StFlush;
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FLUSH_LAST) begin
                    ptr_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                dump_data_d  = dmem_dataOut;
                dump_addr_d  = ptr_q;
                dump_valid_d = 1'b1;
                state_d      = StHold;
            end
            StHold: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    // The last location goes straight to DONE, so ptr never wraps.
                    if (ptr_q == PTR_LAST) begin
                        state_d = StDone;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = StIssue;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (RESET) begin
            state_d        = StRun;
            ptr_d          = '0;
            flush_cnt_d    = '0;
            cycle_count_d  = '0;
            final_cycles_d = '0;
            dump_addr_d    = '0;
            dump_data_d    = '0;
            dump_valid_d   = 1'b0;
        end
    end

    // CPU owns DMEM during RUN/FLUSH and while RESET is high; the dump engine only reads.
    always_comb begin
        dmem_memEn   = 1'b0;
        dmem_memWrEn = 1'b0;
        dmem_memAddr = '0;
        dmem_dataIn  = '0;
        if (RESET || state_q == StRun || state_q == StFlush) begin
            dmem_memEn   = cpu_memEn;
            dmem_memWrEn = cpu_memWrEn;
            dmem_memAddr = cpu_memAddr;
            dmem_dataIn  = cpu_dataOut;
        end else if (state_q == StIssue) begin
            dmem_memEn   = 1'b1;
            dmem_memAddr = ptr_q;
        end
    end

    assign dump_valid   = dump_valid_q;
    assign dump_addr    = dump_addr_q;
    assign dump_data    = dump_data_q;
    assign cycle_count  = cycle_count_q;
    assign final_cycles = final_cycles_q;
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: DMEM model, scoreboard of expected dump beats, directed phases
// for reset, NOP/flush, full dump, backpressure, CPU isolation and reset mid-dump.
module tb_dmem_dump_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int DEPTH = 512;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [0:31]   instruction;
    logic          cpu_memEn, cpu_memWrEn;
    logic [0:AW-1] cpu_memAddr;
    logic [0:DW-1] cpu_dataOut;
    logic          dmem_memEn, dmem_memWrEn;
    logic [0:AW-1] dmem_memAddr;
    logic [0:DW-1] dmem_dataIn, dmem_dataOut;
    logic          dump_valid, dump_ready;
    logic [0:AW-1] dump_addr;
    logic [0:DW-1] dump_data;
    logic [0:31]   cycle_count, final_cycles;
    logic          done;

    always #5 CLK = ~CLK;

    dmem_dump_ctrl #(
        .FLUSH_CYCLES(5),
        .DEPTH       (DEPTH),
        .AW          (AW),
        .DW          (DW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .instruction (instruction),
        .cpu_memEn   (cpu_memEn),
        .cpu_memWrEn (cpu_memWrEn),
        .cpu_memAddr (cpu_memAddr),
        .cpu_dataOut (cpu_dataOut),
        .dmem_memEn  (dmem_memEn),
        .dmem_memWrEn(dmem_memWrEn),
        .dmem_memAddr(dmem_memAddr),
        .dmem_dataIn (dmem_dataIn),
        .dmem_dataOut(dmem_dataOut),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .cycle_count (cycle_count),
        .final_cycles(final_cycles),
        .done        (done)
    );

    // Synchronous-read DMEM model; preload fills mem[i] = i*3.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;
    logic          preload;

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i * 3);
        end else if (dmem_memEn && dmem_memWrEn) begin
            mem[dmem_memAddr] <= dmem_dataIn;
        end
        if (dmem_memEn && !dmem_memWrEn) rd_q <= mem[dmem_memAddr];
    end
    assign dmem_dataOut = rd_q;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         sb_b;
    logic [DW-1:0] exp_mem [DEPTH];
    int            checks   = 0;
    int            failures = 0;
    logic [0:31]   issue_cc;
    logic          ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.a = AW'(i);
            b.d = exp_mem[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits for count==cc, presents one NOP, then returns in the first FLUSH cycle.
    task automatic nop_at(input int cc);
        int n = 0;
        instruction = 32'h0000_0013;
        while (cycle_count != 32'(cc) && n < 200) begin
            tick();
            n++;
        end
        check("nop_cycle", cycle_count, 64'(cc));
        instruction = 32'h0000_0000;
        tick();
        instruction = 32'h0000_0013;
        check("final_cycles", final_cycles, 64'(cc));
    endtask

    task automatic wait_beat(input int addr);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (dump_valid && dump_addr == AW'(addr)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_beat", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 3000 && !done; n++) tick();
        check(name, 64'(done), 64'd1);
    endtask

    // Scoreboard monitor: pops one expected beat per accepted handshake.
    always @(negedge CLK) begin
        if (!RESET && dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got beat addr %0d, expected none", dump_addr);
            end else begin
                sb_b = exp_q.pop_front();
                check("sb_addr", 64'(dump_addr), 64'(sb_b.a));
                check("sb_data", dump_data, sb_b.d);
            end
        end
    end

    initial begin
        RESET       = 1'b1;
        instruction = 32'h0000_0000;
        dump_ready  = 1'b1;
        cpu_memEn   = 1'b0;
        cpu_memWrEn = 1'b0;
        cpu_memAddr = '0;
        cpu_dataOut = '0;
        preload     = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(i * 3);
        exp_mem[7] = 64'hDEAD;

        // Reset values with random CPU traffic (NOP on instruction must be ignored).
        for (int i = 0; i < 5; i++) begin
            tick();
            cpu_memEn   = 1'($urandom);
            cpu_memWrEn = 1'($urandom);
            cpu_memAddr = AW'($urandom);
            cpu_dataOut = {$urandom, $urandom};
            #1;
            check("rst_memEn", 64'(dmem_memEn), 64'(cpu_memEn));
            check("rst_memWrEn", 64'(dmem_memWrEn), 64'(cpu_memWrEn));
            check("rst_memAddr", 64'(dmem_memAddr), 64'(cpu_memAddr));
            check("rst_dataIn", dmem_dataIn, cpu_dataOut);
            check("rst_valid", 64'(dump_valid), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_cycles", cycle_count, 64'd0);
        end
        cpu_memEn   = 1'b0;
        cpu_memWrEn = 1'b0;
        preload     = 1'b1;
        tick();
        preload     = 1'b0;

        // Run 1: NOP at count 9, CPU keeps DMEM 5 cycles, then full dump without stalls.
        push_beats(DEPTH);
        RESET       = 1'b0;
        instruction = 32'h0000_0013;
        nop_at(9);
        for (int i = 1; i <= 5; i++) begin
            cpu_memEn   = 1'b1;
            cpu_memWrEn = (i == 2);
            cpu_memAddr = (i == 2) ? AW'(7) : AW'(i * 11);
            cpu_dataOut = (i == 2) ? 64'hDEAD : 64'h0;
            #1;
            check("flush_memEn", 64'(dmem_memEn), 64'(cpu_memEn));
            check("flush_memWrEn", 64'(dmem_memWrEn), 64'(cpu_memWrEn));
            check("flush_memAddr", 64'(dmem_memAddr), 64'(cpu_memAddr));
            check("flush_dataIn", dmem_dataIn, cpu_dataOut);
            tick();
        end
        cpu_memEn   = 1'b0;
        cpu_memWrEn = 1'b0;
        #1;
        check("issue_memEn", 64'(dmem_memEn), 64'd1);
        check("issue_memWrEn", 64'(dmem_memWrEn), 64'd0);
        check("issue_memAddr", 64'(dmem_memAddr), 64'd0);
        check("issue_cycle", cycle_count, 64'd15);
        issue_cc = cycle_count;
        wait_done("run1_done");
        check("done_latency", cycle_count - issue_cc, 64'd1536);
        check("done_valid", 64'(dump_valid), 64'd0);
        check("run1_drain", 64'(exp_q.size()), 64'd0);

        // Run 2: backpressure at beat 3, isolated CPU write to 20, RESET at beat 100.
        RESET = 1'b1;
        repeat (3) tick();
        check("rst2_done", 64'(done), 64'd0);
        check("rst2_cycles", cycle_count, 64'd0);
        push_beats(100);
        RESET = 1'b0;
        nop_at(4);
        wait_beat(3);
        dump_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("stall_valid", 64'(dump_valid), 64'd1);
            check("stall_addr", 64'(dump_addr), 64'd3);
            check("stall_data", dump_data, exp_mem[3]);
            check("stall_noread", 64'(dmem_memEn), 64'd0);
            tick();
        end
        dump_ready = 1'b1;
        wait_beat(8);
        cpu_memEn   = 1'b1;
        cpu_memWrEn = 1'b1;
        cpu_memAddr = AW'(20);
        cpu_dataOut = 64'hBAD0_BAD0;
        for (int i = 0; i < 6; i++) begin
            check("iso_memWrEn", 64'(dmem_memWrEn), 64'd0);
            tick();
        end
        cpu_memEn   = 1'b0;
        cpu_memWrEn = 1'b0;
        wait_beat(100);
        RESET       = 1'b1;
        cpu_memEn   = 1'b1;
        cpu_memAddr = AW'(77);
        tick();
        check("mid_valid", 64'(dump_valid), 64'd0);
        check("mid_done", 64'(done), 64'd0);
        check("mid_cycles", cycle_count, 64'd0);
        check("mid_final", final_cycles, 64'd0);
        check("mid_addr", 64'(dump_addr), 64'd0);
        check("mid_data", dump_data, 64'd0);
        check("mid_memEn", 64'(dmem_memEn), 64'd1);
        check("mid_memWrEn", 64'(dmem_memWrEn), 64'd0);
        check("mid_memAddr", 64'(dmem_memAddr), 64'd77);
        check("run2_drain", 64'(exp_q.size()), 64'd0);

        // Run 3: fresh NOP restarts the dump from address 0.
        cpu_memEn = 1'b0;
        tick();
        push_beats(DEPTH);
        RESET = 1'b0;
        nop_at(25);
        wait_done("run3_done");
        check("run3_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
